subtree_response_collector: RTL and testbench
=============================================

# subtree_response_collector

Fan-in counterpart of the hierarchy fan-out node. The node instantiates `N_CHILD` children. This block is the upstream return path: on a round start it collects exactly one response word from each child. It forwards each word up the tree through a single registered valid/ready port, tagged with the child index, then reports round completion or timeout with a mask of children that did not respond.

## Interface
Parameters:
- `N_CHILD`, 5: number of child response ports (2..8).
- `DATA_W`, 16: response word width.
- `TIMEOUT`, 64: cycles allowed in COLLECT before the round is abandoned. 0 disables the timeout.

Ports:
- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `round_start`  in  1  single-cycle pulse that opens a collection round.
- `child_valid`  in  N_CHILD  per-child response valid.
- `child_data`  in  N_CHILD*DATA_W  per-child word; child i occupies bits [i*DATA_W +: DATA_W].
- `child_ready`  out  N_CHILD  per-child accept (combinational).
- `up_valid`  out  1  registered upstream valid.
- `up_data`  out  DATA_W  registered upstream word.
- `up_src`  out  3  index of the child that produced `up_data`.
- `up_ready`  in  1  upstream accept.
- `busy`  out  1  high when the state is not IDLE.
- `round_done`  out  1  one-cycle pulse at the end of a round.
- `round_timeout`  out  1  registered; set when the last round ended by timeout.
- `round_missing`  out  N_CHILD  registered; children not heard in the last round.

## Operation
- FSM states: IDLE, COLLECT, DONE.
  - IDLE -> COLLECT on `round_start`. On entry, the `seen` mask and the timer clear, and `round_timeout` and `round_missing` clear.
  - COLLECT -> DONE when (`seen` is all ones, or the timeout has fired) and the output register is empty or draining this cycle (`!up_valid || up_ready`).
  - DONE -> IDLE unconditionally after one cycle. `round_done`=1 only in DONE.
- `round_start` is ignored in COLLECT and in DONE.
- Arbitration is round-robin.
  - Eligible children: `child_valid[i] & ~seen[i]`.
  - Search starts at pointer `ptr`, which resets to 0. Grant goes to the first eligible child in circular order.
- `child_ready[i]` = COLLECT & grant[i] & !timeout_fired & (`!up_valid || up_ready`). At most one bit is high at any time.
- On accept:
  - `up_data` <= the child's word, `up_src` <= i, `up_valid` <= 1.
  - `seen[i]` <= 1.
  - `ptr` <= (i+1) mod `N_CHILD`.
- `up_valid` clears when `up_ready` is high and no new accept happens in the same cycle. Accept and drain in the same cycle keeps `up_valid`=1 with the new word.
- While `up_valid && !up_ready`, the values of `up_data` and `up_src` are held stable.
- A child that has already responded is never readied again within the round, even if it holds `child_valid` high.
- Timer:
  - Counts cycles in COLLECT and is sized to clog2(TIMEOUT+1) bits.
  - The timeout fires when the timer equals TIMEOUT and `seen` is not full. Once fired, the flag is sticky for the round and no new accepts occur.
  - On the COLLECT -> DONE transition: `round_timeout` <= timeout_fired and `round_missing` <= ~seen. Both hold until the next round start.
- Reset:
  - Every output register clears: `up_valid`=0, `up_data`=0, `up_src`=0, `round_done`=0, `round_timeout`=0, `round_missing`=0.
  - State returns to IDLE, so `busy`=0 and `child_ready`=0.
  - `seen`=0 and `ptr`=0.
  - Reset mid-round discards any in-flight word.

## Timing
- `round_start` sampled in cycle t puts the block in COLLECT at t+1. The first `child_ready` can assert at t+1.
- Child accept in cycle c gives `up_valid` at c+1. The throughput is one word per cycle with `up_ready` held high.
- The last word is drained in cycle d; DONE and the `round_done` pulse follow at d+1, and `busy` drops at d+2.
- `child_ready` is combinational from `child_valid`, `up_valid` and `up_ready`. There is no combinational path from `child_valid` to `up_valid`.

## Test plan
- **All children respond at once.** After reset, pulse `round_start` at cycle 0. All 5 children drive valid with data 0x1000+i, and `up_ready`=1.
  - Required: `up_src` = 0,1,2,3,4 on cycles 2..6 with matching data.
  - `round_done` high only in cycle 7, `round_timeout`=0, `round_missing`=5'b00000.
- **Backpressure.** Drop `up_ready` for 3 cycles while `up_valid`=1.
  - Required: `up_data` and `up_src` stable, all `child_ready`=0, no words lost.
  - Order resumes round-robin from `ptr`.
- **Duplicate suppression.** Child 2 holds valid with 0xBEEF for the whole round.
  - Required: exactly one upstream word with `up_src`=2.
  - `child_ready[2]` stays 0 after its accept.
- **Timeout.** Set TIMEOUT=20. Child 3 never asserts valid.
  - Required: 4 words forwarded, then `round_done` pulses with `round_timeout`=1 and `round_missing`=5'b01000.
  - A late `child_valid[3]` is never readied.
- **Reset mid-round.** Assert `rst` while `up_valid`=1 and `busy`=1.
  - Required: next cycle `up_valid`=0, `busy`=0, all `child_ready`=0.
  - Children are ignored until a fresh `round_start`.
- **round_start while busy.** Pulse `round_start` again during COLLECT.
  - Required: `seen` and the timer are unaffected, and only one `round_done` pulse occurs.

Source files
------------

// File: rtl/subtree_response_collector.sv
// Upstream return path of a hierarchy node: gathers one word per child per round,
// forwards them round-robin through a registered valid/ready port, then reports the outcome.
module subtree_response_collector #(
    parameter int unsigned N_CHILD = 5,
    parameter int unsigned DATA_W  = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      round_start,
    input  logic [N_CHILD-1:0]        child_valid,
    input  logic [N_CHILD*DATA_W-1:0] child_data,
    output logic [N_CHILD-1:0]        child_ready,
    output logic                      up_valid,
    output logic [DATA_W-1:0]         up_data,
    output logic [2:0]                up_src,
    input  logic                      up_ready,
    output logic                      busy,
    output logic                      round_done,
    output logic                      round_timeout,
    output logic [N_CHILD-1:0]        round_missing
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

    state_e             state_q;
    logic [N_CHILD-1:0] seen_q;
    logic [2:0]         ptr_q;
    logic [TW-1:0]      timer_q;

    logic [N_CHILD-1:0] eligible;
    logic [2:0]         grant_idx;
    logic [2:0]         idx;
    logic               found;
    logic               all_seen;
    logic               timeout_fired;
    logic               can_load;
    logic               accept;

    assign all_seen = &seen_q;
    assign eligible = child_valid & ~seen_q;
    assign can_load = !up_valid || up_ready;
    // Timer saturates at TIMEOUT, so the fired condition stays true for the rest of the round.
    assign timeout_fired = (TIMEOUT != 0) && (timer_q == TW'(TIMEOUT)) && !all_seen;
    assign accept = (state_q == StCollect) && found && !timeout_fired && can_load;
    assign child_ready = accept ? (N_CHILD'(1) << grant_idx) : '0;
    assign busy = (state_q != StIdle);

    // Circular search for the first eligible child starting at ptr_q.
    always_comb begin
        grant_idx = '0;
        idx       = '0;
        found     = 1'b0;
        for (int k = 0; k < N_CHILD; k++) begin
            idx = 3'((32'(ptr_q) + 32'(k)) % N_CHILD);
            if (!found && eligible[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StIdle;
            seen_q        <= '0;
            ptr_q         <= '0;
            timer_q       <= '0;
            up_valid      <= 1'b0;
            up_data       <= '0;
            up_src        <= '0;
            round_done    <= 1'b0;
            round_timeout <= 1'b0;
            round_missing <= '0;
        end else begin
            round_done <= 1'b0;

            if (accept) begin
                up_valid          <= 1'b1;
                up_data           <= child_data[grant_idx*DATA_W +: DATA_W];
                up_src            <= grant_idx;
                seen_q[grant_idx] <= 1'b1;
                ptr_q             <= (grant_idx == 3'(N_CHILD - 1)) ? 3'd0 : grant_idx + 3'd1;
            end else if (up_ready) begin
                up_valid <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (round_start) begin
                        state_q       <= StCollect;
                        seen_q        <= '0;
                        timer_q       <= '0;
                        round_timeout <= 1'b0;
                        round_missing <= '0;
                    end
                end
                StCollect: begin
                    if (timer_q != TW'(TIMEOUT)) begin
                        timer_q <= timer_q + 1'b1;
                    end
                    if ((all_seen || timeout_fired) && can_load) begin
                        state_q       <= StDone;
                        round_done    <= 1'b1;
                        round_timeout <= timeout_fired;
                        round_missing <= ~seen_q;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_subtree_response_collector.sv
// Self-checking bench for subtree_response_collector: scoreboard of expected upstream words
// plus per-scenario checks of round completion, timeout, backpressure and reset.
module tb_subtree_response_collector;

    localparam int N  = 5;
    localparam int DW = 16;
    localparam int TO = 20;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          round_start = 1'b0;
    logic [N-1:0]  child_valid = '0;
    logic [N*DW-1:0] child_data = '0;
    logic [N-1:0]  child_ready;
    logic          up_valid;
    logic [DW-1:0] up_data;
    logic [2:0]    up_src;
    logic          up_ready = 1'b0;
    logic          busy;
    logic          round_done;
    logic          round_timeout;
    logic [N-1:0]  round_missing;

    subtree_response_collector #(
        .N_CHILD (N),
        .DATA_W  (DW),
        .TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .round_start   (round_start),
        .child_valid   (child_valid),
        .child_data    (child_data),
        .child_ready   (child_ready),
        .up_valid      (up_valid),
        .up_data       (up_data),
        .up_src        (up_src),
        .up_ready      (up_ready),
        .busy          (busy),
        .round_done    (round_done),
        .round_timeout (round_timeout),
        .round_missing (round_missing)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]    src;
        logic [DW-1:0] data;
        int            cyc;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [N-1:0]  want = '0;
    logic [N-1:0]  hold = '0;
    logic [N-1:0]  sent = '0;
    logic [N-1:0]  forbid = '0;
    logic [DW-1:0] cdata [N];
    logic          s_valid;
    logic          s_busy;
    logic [DW-1:0] s_data;
    logic [2:0]    s_src;
    logic [N-1:0]  s_ready;
    int            done_cnt = 0;
    int            done_cyc = -1;
    logic          done_to = 1'b0;
    logic [N-1:0]  done_miss = '0;

    // One clock: drive inputs at negedge, sample #1 later, score the handshakes of the next edge.
    task automatic cycle(input logic ur, input logic rs, input logic rr);
        exp_t e;
        @(negedge clk);
        rst = rr;
        round_start = rs;
        up_ready = ur;
        for (int i = 0; i < N; i++) begin
            child_valid[i] = want[i] && (!sent[i] || hold[i]);
            child_data[i*DW +: DW] = cdata[i];
        end
        #1;
        s_valid = up_valid;
        s_busy  = busy;
        s_data  = up_data;
        s_src   = up_src;
        s_ready = child_ready;
        if (!rr) begin
            if (up_valid && up_ready) begin
                n_cmp++;
                if (sb.size() == 0) begin
                    n_err++;
                    $display("FAIL sb_extra: cyc %0d got src=%0d data=%h, required no word",
                             cyc, up_src, up_data);
                end else begin
                    e = sb.pop_front();
                    if (up_src !== e.src || up_data !== e.data || (e.cyc >= 0 && cyc != e.cyc)) begin
                        n_err++;
                        $display("FAIL sb_word: got src=%0d data=%h cyc=%0d, required src=%0d data=%h cyc=%0d",
                                 up_src, up_data, cyc, e.src, e.data, e.cyc);
                    end
                end
            end
            n_cmp++;
            if ($countones(child_ready) > 1 || (child_ready & (sent | forbid)) != '0) begin
                n_err++;
                $display("FAIL child_ready: cyc %0d got %b, required one-hot excluding %b",
                         cyc, child_ready, sent | forbid);
            end
            for (int i = 0; i < N; i++) begin
                if (child_ready[i] && child_valid[i]) sent[i] = 1'b1;
            end
            if (round_done) begin
                done_cnt++;
                done_cyc  = cyc;
                done_to   = round_timeout;
                done_miss = round_missing;
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b1);
    endtask

    task automatic begin_round();
        sent = '0;
        hold = '0;
        forbid = '0;
        cyc = 0;
        done_cnt = 0;
        done_cyc = -1;
        sb.delete();
    endtask

    task automatic push(input int src, input int data, input int c);
        exp_t e;
        e.src = 3'(src);
        e.data = DW'(data);
        e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic end_checks(input string name, input int exp_cyc, input logic exp_to,
                              input logic [N-1:0] exp_miss);
        n_cmp++;
        if (sb.size() != 0) begin
            n_err++;
            $display("FAIL %s_words_lost: got %0d pending, required 0", name, sb.size());
        end
        n_cmp++;
        if (done_cnt != 1 || done_cyc != exp_cyc) begin
            n_err++;
            $display("FAIL %s_done: got %0d pulses last at %0d, required 1 at %0d",
                     name, done_cnt, done_cyc, exp_cyc);
        end
        n_cmp++;
        if (done_to !== exp_to || done_miss !== exp_miss) begin
            n_err++;
            $display("FAIL %s_status: got timeout=%b missing=%b, required timeout=%b missing=%b",
                     name, done_to, done_miss, exp_to, exp_miss);
        end
    endtask

    task automatic test_reset();
        want = '1;
        sent = '0;
        do_reset();
        cycle(1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({s_valid, s_data, s_src} !== '0) begin
            n_err++;
            $display("FAIL reset_up: got valid=%b data=%h src=%0d, required 0/0/0",
                     s_valid, s_data, s_src);
        end
        n_cmp++;
        if ({s_busy, s_ready, round_done} !== '0) begin
            n_err++;
            $display("FAIL reset_ctrl: got busy=%b ready=%b done=%b, required 0",
                     s_busy, s_ready, round_done);
        end
        n_cmp++;
        if (round_timeout !== 1'b0 || round_missing !== '0) begin
            n_err++;
            $display("FAIL reset_status: got timeout=%b missing=%b, required 0/00000",
                     round_timeout, round_missing);
        end
    endtask

    task automatic test_all_at_once();
        do_reset();
        want = '1;
        for (int i = 0; i < N; i++) cdata[i] = DW'(16'h1000 + i);
        begin_round();
        for (int i = 0; i < N; i++) push(i, 16'h1000 + i, 2 + i);
        for (int k = 0; k < 12; k++) begin
            cycle(1'b1, k == 0, 1'b0);
            if (k == 7 || k == 8) begin
                n_cmp++;
                if (s_busy !== (k == 7)) begin
                    n_err++;
                    $display("FAIL all_busy: cyc %0d got %b, required %b", k, s_busy, k == 7);
                end
            end
        end
        end_checks("all", 7, 1'b0, 5'b00000);
    endtask

    task automatic test_backpressure();
        do_reset();
        want = '1;
        for (int i = 0; i < N; i++) cdata[i] = DW'(16'h2000 + i);
        begin_round();
        push(0, 16'h2000, 2);
        for (int i = 1; i < N; i++) push(i, 16'h2000 + i, 5 + i);
        for (int k = 0; k < 14; k++) begin
            cycle(!(k >= 3 && k <= 5), k == 0, 1'b0);
            if (k >= 3 && k <= 5) begin
                n_cmp++;
                if (s_valid !== 1'b1 || s_src !== 3'd1 || s_data !== 16'h2001 || s_ready !== '0) begin
                    n_err++;
                    $display("FAIL bp_hold: cyc %0d got v=%b src=%0d data=%h rdy=%b, required 1/1/2001/0",
                             k, s_valid, s_src, s_data, s_ready);
                end
            end
        end
        end_checks("bp", 10, 1'b0, 5'b00000);
    endtask

    task automatic test_duplicate();
        do_reset();
        want = '1;
        for (int i = 0; i < N; i++) cdata[i] = DW'(16'h3000 + i);
        cdata[2] = 16'hBEEF;
        begin_round();
        hold[2] = 1'b1;
        for (int i = 0; i < N; i++) push(i, (i == 2) ? 16'hBEEF : 16'h3000 + i, 2 + i);
        for (int k = 0; k < 12; k++) cycle(1'b1, k == 0, 1'b0);
        end_checks("dup", 7, 1'b0, 5'b00000);
    endtask

    task automatic test_timeout();
        do_reset();
        want = 5'b10111;
        for (int i = 0; i < N; i++) cdata[i] = DW'(16'h4000 + i);
        begin_round();
        push(0, 16'h4000, 2);
        push(1, 16'h4001, 3);
        push(2, 16'h4002, 4);
        push(4, 16'h4004, 5);
        for (int k = 0; k < 30; k++) begin
            if (k >= TO + 1) begin
                want[3] = 1'b1;
                forbid[3] = 1'b1;
            end
            cycle(1'b1, k == 0, 1'b0);
        end
        end_checks("to", TO + 2, 1'b1, 5'b01000);
        n_cmp++;
        if (round_timeout !== 1'b1 || round_missing !== 5'b01000) begin
            n_err++;
            $display("FAIL to_held: got timeout=%b missing=%b, required 1/01000",
                     round_timeout, round_missing);
        end
        forbid = '0;
    endtask

    task automatic test_reset_mid_round();
        do_reset();
        want = '1;
        for (int i = 0; i < N; i++) cdata[i] = DW'(16'h5000 + i);
        begin_round();
        for (int k = 0; k < 4; k++) cycle(k < 2, k == 0, 1'b0);
        n_cmp++;
        if (s_valid !== 1'b1 || s_busy !== 1'b1) begin
            n_err++;
            $display("FAIL mid_pre: got valid=%b busy=%b, required 1/1", s_valid, s_busy);
        end
        cycle(1'b0, 1'b0, 1'b1);
        for (int k = 0; k < 5; k++) begin
            cycle(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (s_valid !== 1'b0 || s_busy !== 1'b0 || s_ready !== '0) begin
                n_err++;
                $display("FAIL mid_after: step %0d got valid=%b busy=%b ready=%b, required 0/0/0",
                         k, s_valid, s_busy, s_ready);
            end
        end
        begin_round();
        for (int i = 0; i < N; i++) push(i, 16'h5000 + i, 2 + i);
        for (int k = 0; k < 12; k++) cycle(1'b1, k == 0, 1'b0);
        end_checks("mid", 7, 1'b0, 5'b00000);
    endtask

    task automatic test_start_while_busy();
        do_reset();
        want = 5'b10111;
        for (int i = 0; i < N; i++) cdata[i] = DW'(16'h6000 + i);
        begin_round();
        push(0, 16'h6000, 2);
        push(1, 16'h6001, 3);
        push(2, 16'h6002, 4);
        push(4, 16'h6004, 5);
        for (int k = 0; k < 30; k++) begin
            cycle(1'b1, k == 0 || k == 10 || k == TO + 2, 1'b0);
            if (k == TO + 3 || k == TO + 4) begin
                n_cmp++;
                if (s_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL busy_restart: cyc %0d got busy=%b, required 0", k, s_busy);
                end
            end
        end
        end_checks("restart", TO + 2, 1'b1, 5'b01000);
    endtask

    initial begin
        for (int i = 0; i < N; i++) cdata[i] = '0;
        test_reset();
        test_all_at_once();
        test_backpressure();
        test_duplicate();
        test_timeout();
        test_reset();
        test_reset_mid_round();
        test_start_while_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
